bus_xfer_arbiter: RTL

- Parametrised successor to the datapath bus multiplexer: N sources of WIDTH bits, each with its own drive-enable.
- Selects one source per cycle by fixed-priority or round-robin arbitration.
- Provides a zero-latency combinational bus and a registered bus copy.
- Flags multi-driver conflicts (sticky) and counts transfers.
- Sits between the register file / special registers (HI, LO, Z, PC, MDR, InPort, Y) and all bus consumers.

---
 rtl/bus_xfer_arbiter_if.sv | 31 +++
 rtl/bus_xfer_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bus_xfer_arbiter_if.sv
// Bus bundle between N drive-enabled sources and the bus consumers.
// The slave modport is the arbiter's view; the master modport is the sources/consumers view.
interface bus_xfer_arbiter_if #(
  parameter int N     = 24,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [N-1:0]       src_en;
  logic [N*WIDTH-1:0] src_data;
  logic               conflict_clr;
  logic [WIDTH-1:0]   bus_comb;
  logic [WIDTH-1:0]   bus_q;
  logic               bus_valid;
  logic [N-1:0]       grant;
  logic               conflict;
  logic [N-1:0]       conflict_vec;
  logic [CNT_W-1:0]   xfer_count;
  logic [CNT_W-1:0]   conflict_count;

  modport master (
    output src_en, src_data, conflict_clr,
    input  bus_comb, bus_q, bus_valid, grant, conflict, conflict_vec,
           xfer_count, conflict_count
  );

  modport slave (
    input  src_en, src_data, conflict_clr,
    output bus_comb, bus_q, bus_valid, grant, conflict, conflict_vec,
           xfer_count, conflict_count
  );
endinterface

// File: rtl/bus_xfer_arbiter.sv
// N-source bus arbiter: fixed-priority or round-robin grant, combinational and
// registered bus, sticky multi-driver conflict capture and transfer counting.
module bus_xfer_arbiter #(
  parameter int N        = 24,
  parameter int WIDTH    = 32,
  parameter int ARB_MODE = 0,
  parameter int CNT_W    = 16
) (
  input logic               clock,
  input logic               clear,
  bus_xfer_arbiter_if.slave bus
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 32 || WIDTH < 1 || ARB_MODE < 0 || ARB_MODE > 1) begin : g_bad_params
    $error("bus_xfer_arbiter: need 2 <= N <= 32, WIDTH >= 1, ARB_MODE in {0,1}");
  end

  logic [PTR_W-1:0] r_rr_ptr;
  logic [WIDTH-1:0] r_bus_q;
  logic             r_bus_valid;
  logic             r_conflict;
  logic [N-1:0]     r_conflict_vec;
  logic [CNT_W-1:0] r_xfer_count;
  logic [CNT_W-1:0] r_conflict_count;

  logic             w_hit;
  logic [PTR_W-1:0] w_idx;
  logic [N-1:0]     w_grant;
  logic             w_multi;
  logic [WIDTH-1:0] w_masked [N];
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_bus_comb;

  always_comb begin
    logic [PTR_W:0] v_sum;
    w_hit = 1'b0;
    w_idx = '0;
    v_sum = '0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (bus.src_en[i]) begin
          w_hit = 1'b1;
          w_idx = PTR_W'(i);
        end
      end
    end else begin
      // Walk offsets farthest-first so the slot nearest after r_rr_ptr is assigned last.
      for (int off = N; off >= 1; off--) begin
        v_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(off);
        if (v_sum >= (PTR_W+1)'(N)) begin
          v_sum = v_sum - (PTR_W+1)'(N);
        end
        if (bus.src_en[v_sum[PTR_W-1:0]]) begin
          w_hit = 1'b1;
          w_idx = v_sum[PTR_W-1:0];
        end
      end
    end
  end

  assign w_grant = w_hit ? (N'(1) << w_idx) : '0;
  assign w_multi = |(bus.src_en & (bus.src_en - N'(1)));

  for (genvar gi = 0; gi < N; gi++) begin : g_mux
    assign w_masked[gi] = bus.src_data[gi*WIDTH +: WIDTH] & {WIDTH{w_grant[gi]}};
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      w_sel_data = w_sel_data | w_masked[i];
    end
  end

  // With nobody driving, the bus shows the last transferred value instead of floating.
  assign w_bus_comb = w_hit ? w_sel_data : r_bus_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_rr_ptr         <= PTR_W'(N - 1);
      r_bus_q          <= '0;
      r_bus_valid      <= 1'b0;
      r_conflict       <= 1'b0;
      r_conflict_vec   <= '0;
      r_xfer_count     <= '0;
      r_conflict_count <= '0;
    end else begin
      if (w_hit) begin
        r_bus_q      <= w_bus_comb;
        r_bus_valid  <= 1'b1;
        r_xfer_count <= r_xfer_count + 1'b1;
        r_rr_ptr     <= w_idx;
      end else begin
        r_bus_valid  <= 1'b0;
      end

      if (w_multi) begin
        r_conflict <= 1'b1;
        if (!r_conflict || bus.conflict_clr) begin
          r_conflict_vec <= bus.src_en;
        end
        if (r_conflict_count != '1) begin
          r_conflict_count <= r_conflict_count + 1'b1;
        end
      end else if (bus.conflict_clr) begin
        r_conflict     <= 1'b0;
        r_conflict_vec <= '0;
      end
    end
  end

  assign bus.bus_comb       = w_bus_comb;
  assign bus.bus_q          = r_bus_q;
  assign bus.bus_valid      = r_bus_valid;
  assign bus.grant          = w_grant;
  assign bus.conflict       = r_conflict;
  assign bus.conflict_vec   = r_conflict_vec;
  assign bus.xfer_count     = r_xfer_count;
  assign bus.conflict_count = r_conflict_count;
endmodule
